// File: rtl/mc_control_pkg.sv
// mc_control_pkg: opcodes, ALU/operand select codes, FSM states and opcode classifier for mc_control
package mc_control_pkg;
  localparam int REGWIDTH = 32;
  localparam int ALUOPWIDTH = 2;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [ALUOPWIDTH-1:0] ALU_ADD = 2'd0, ALU_R = 2'd1, ALU_I = 2'd2, ALU_BRANCH = 2'd3;
  localparam logic [1:0] SRC_REG = 2'd0, SRC_IMM = 2'd1, SRC_FOUR = 2'd2;
  localparam logic [1:0] SRC1_REG = 2'd0, SRC1_ZERO = 2'd1, SRC1_PC = 2'd2;
  localparam logic PC_PPC = 1'b0, PC_REG = 1'b1;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_t;
  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      OP_REG:    return C_R;
      OP_IMM:    return C_I;
      OP_LOAD:   return C_LOAD;
      OP_STORE:  return C_STORE;
      OP_BRANCH: return C_BRANCH;
      OP_JAL:    return C_JAL;
      OP_JALR:   return C_JALR;
      OP_LUI:    return C_LUI;
      OP_AUIPC:  return C_AUIPC;
      default:   return C_ILL;
    endcase
  endfunction
endpackage

// File: rtl/mc_control_imm_gen.sv
// mc_control_imm_gen: sign-extended I/S/B/U/J immediate selected by the instruction's opcode
module mc_control_imm_gen
  import mc_control_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);
  cls_t c;
  assign c = classify(instr_i[6:0]);
  always_comb begin
    imm_o = '0;
    case (c)
      C_I, C_LOAD, C_JALR: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      C_STORE:             imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      C_BRANCH:            imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      C_LUI, C_AUIPC:      imm_o = {instr_i[31:12], 12'b0};
      C_JAL:               imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default:             imm_o = '0;
    endcase
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control FSM; define ILLEGAL_TRAP_EN to halt on unrecognised opcodes
module mc_control #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          REGWIDTH   = mc_control_pkg::REGWIDTH,
  parameter int          ALUOPWIDTH = mc_control_pkg::ALUOPWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  input  logic [REGWIDTH-1:0]   dmem_rdata,
  output logic [31:0]           pc_o,
  output logic [ALUOPWIDTH-1:0] alu_op,
  output logic [1:0]            alu_src,
  output logic [1:0]            alu_src1,
  output logic                  pc_src,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [31:0]           imm32,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  input  logic                  alu_zero,
  input  logic [REGWIDTH-1:0]   alu_result,
  input  logic [REGWIDTH-1:0]   alu_pcout,
  output logic                  rf_we,
  output logic [REGWIDTH-1:0]   rf_wdata,
  output logic                  illegal_o
);
  import mc_control_pkg::*;
  state_t state_q;
  cls_t cls;
  logic [31:0] instr_q, pc_q, pc_d;
  logic [REGWIDTH-1:0] res_q, pcout_q, load_q;
  logic zero_q, wr_cls;
  logic [ALUOPWIDTH-1:0] alu_op_q;
  logic [1:0] src_q, src1_q;
  logic psrc_q;
  assign cls = classify(instr_q[6:0]);
  assign wr_cls = cls inside {C_R, C_I, C_LOAD, C_JAL, C_JALR, C_LUI, C_AUIPC};
  assign pc_d = cls == C_JALR ? (pcout_q & ~32'h1) :
                ((cls == C_BRANCH && zero_q) || cls == C_JAL) ? pcout_q : pc_q + 32'd4;
  // gated by rst_n so the request drops the instant reset asserts
  assign imem_req = rst_n && state_q == S_FETCH;
  assign dmem_req = state_q == S_MEM;
  assign dmem_we  = dmem_req && cls == C_STORE;
  assign rf_we    = state_q == S_WB && wr_cls && instr_q[11:7] != 5'd0;
  assign rf_wdata = cls == C_LOAD ? load_q : res_q;
  assign pc_o     = pc_q;
  assign alu_op   = alu_op_q;
  assign alu_src  = src_q;
  assign alu_src1 = src1_q;
  assign pc_src   = psrc_q;
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign rd       = instr_q[11:7];
  assign funct3   = instr_q[14:12];
  assign funct7   = (cls == C_R || (cls == C_I && instr_q[13:12] == 2'b01)) ? instr_q[31:25] : 7'd0;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_o = state_q == S_HALT;
`else
  assign illegal_o = 1'b0;
`endif
  mc_control_imm_gen u_imm (.instr_i(instr_q), .imm_o(imm32));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0000_0013;
      res_q    <= '0;
      pcout_q  <= '0;
      load_q   <= '0;
      zero_q   <= 1'b0;
      alu_op_q <= '0;
      src_q    <= '0;
      src1_q   <= '0;
      psrc_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: if (imem_ack) begin
          instr_q <= imem_rdata;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
          if (cls == C_ILL) state_q <= S_HALT; else
`endif
          begin
            state_q  <= S_EXEC;
            alu_op_q <= cls == C_R ? ALU_R : cls == C_I ? ALU_I : cls == C_BRANCH ? ALU_BRANCH : ALU_ADD;
            src_q    <= cls inside {C_JAL, C_JALR} ? SRC_FOUR :
                        cls inside {C_I, C_LOAD, C_STORE, C_LUI, C_AUIPC} ? SRC_IMM : SRC_REG;
            src1_q   <= cls inside {C_JAL, C_JALR, C_AUIPC} ? SRC1_PC : cls == C_LUI ? SRC1_ZERO : SRC1_REG;
            psrc_q   <= cls == C_JALR ? PC_REG : PC_PPC;
          end
        end
        S_EXEC: begin
          res_q   <= alu_result;
          zero_q  <= alu_zero;
          pcout_q <= alu_pcout;
          state_q <= cls inside {C_LOAD, C_STORE} ? S_MEM : S_WB;
        end
        S_MEM: if (dmem_ack) begin
          load_q  <= dmem_rdata;
          state_q <= S_WB;
        end
        S_WB: begin
          pc_q     <= pc_d;
          state_q  <= S_FETCH;
          alu_op_q <= '0;
          src_q    <= '0;
          src1_q   <= '0;
          psrc_q   <= 1'b0;
        end
        default: state_q <= state_q;
      endcase
    end
endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the RV32I core. It fetches each instruction over a request/acknowledge instruction port and decodes it into the ALU's control and operand-select inputs. It sequences the data-memory access, then performs register writeback and the PC update from the ALU's result, zero flag and branch-target outputs. It owns the architectural PC, and the ALU reads that PC as its `PCin`.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- REGWIDTH, 32, datapath width (from the shared header)
- ALUOPWIDTH, shared-header value, ALU opcode width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data access request; address is alu_result
- dmem_we  out  1  1 = store, 0 = load; qualified by dmem_req
- dmem_ack  in  1  data access complete
- dmem_rdata  in  32  load data, valid with dmem_ack
- pc_o  out  32  current PC, drives the ALU's PCin
- alu_op  out  ALUOPWIDTH  ALU opcode class: R, I, BRANCH or ADD-default
- alu_src  out  2  ALU operand-2 select: REG, IMM or FOUR
- alu_src1  out  2  ALU operand-1 select: REG, ZERO or PC
- pc_src  out  1  branch-target base select: PPC or REG
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25] for R-type and I-type shifts, else 0
- imm32  out  32  sign-extended immediate: I/S/B/U/J format per opcode
- rs1, rs2, rd  out  5 each  register indices
- alu_zero, alu_result, alu_pcout  in  1/32/32  ALU outputs
- rf_we  out  1  register-file write enable; one-cycle pulse
- rf_wdata  out  32  writeback data
- illegal_o  out  1  sticky illegal-instruction flag

## Operation
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req is held high until imem_ack.
  - On imem_ack, instr is latched and the FSM goes to DECODE.
- DECODE:
  - Opcode is classified.
  - rs1, rs2, rd and imm32 are driven from the latched instruction.
  - Next state is EXEC.
- EXEC: ALU controls are driven per class.
  - R: alu_op=R, alu_src1=REG, alu_src=REG.
  - OP-IMM: alu_op=I, alu_src=IMM.
  - LOAD/STORE: alu_op=ADD, alu_src=IMM.
  - BRANCH: alu_op=BRANCH, alu_src=REG, pc_src=PPC.
  - JAL: alu_src1=PC, alu_src=FOUR, pc_src=PPC.
  - JALR: alu_src1=PC, alu_src=FOUR, pc_src=REG.
  - LUI: alu_src1=ZERO, alu_src=IMM.
  - AUIPC: alu_src1=PC, alu_src=IMM.
  - EXEC latches alu_result, alu_zero and alu_pcout.
  - Next state is MEM for loads and stores, otherwise WB.
- MEM:
  - dmem_req is held high, with dmem_we=1 for stores.
  - On dmem_ack, load data is latched and the FSM goes to WB.
- WB:
  - rf_we=1 for R, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC. rf_we is suppressed when rd==0.
  - rf_wdata is the load data for LOAD, otherwise the latched alu_result.
  - PC update:
    - Taken BRANCH (latched zero=1) or JAL: PC = alu_pcout.
    - JALR: PC = alu_pcout & ~32'h1.
    - All other classes: PC = PC+4, modulo 2^32.
  - Next state is FETCH.
- ALU control outputs hold their EXEC values through MEM and WB. They are 0 in FETCH.

## Timing
- Reset values: FSM=FETCH, pc_o=RESET_PC, instr=32'h0000_0013 (NOP). All other outputs are 0.
- imem_req rises in the first cycle after rst_n deasserts.
- Minimum latency with zero-wait acknowledge:
  - 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
  - 5 cycles for loads and stores.
- Each wait cycle on an acknowledge adds one cycle. There is no timeout.
- An acknowledge arriving while its request is low is ignored.
- Reset asserted mid-handshake drops the request immediately and discards any pending acknowledge.
- pc_o changes only on the clock edge that leaves WB.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unrecognised opcode sends DECODE to HALT.
  - In HALT, illegal_o=1, no requests are issued, and the PC is frozen until reset.
- ILLEGAL_TRAP_EN undefined:
  - An unrecognised opcode executes as a NOP: no register write, PC+4.
  - illegal_o is tied to 0 and HALT is unreachable.

## Structure
- Shared header constants:
  - Opcode values.
  - ALU-op class codes: R, I, BRANCH.
  - Operand selects: REG, IMM, ZERO, FOUR, PC, PPC.
  - REGWIDTH and ALUOPWIDTH.
  - FSM state encodings.
- One sub-module, imm_gen: combinational I/S/B/U/J immediate extraction from the instruction and opcode.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles, then release; imem_ack=1 in every cycle, imem_rdata=NOP.
  - Required: pc_o=0 during reset; imem_req=1 in the first cycle after release; pc_o=4 after 4 cycles.
- ADD with delayed fetch:
  - Stimulus: `add x3,x1,x2`, imem_ack delayed 2 cycles; ALU returns alu_result=7.
  - Required: alu_op=R, alu_src=REG; rf_we pulses once with rd=3, rf_wdata=7; 6 cycles total.
- Load:
  - Stimulus: `lw x5,8(x1)`, dmem_ack delayed 1 cycle, dmem_rdata=32'hDEAD_BEEF.
  - Required: alu_src=IMM, imm32=8, dmem_we=0; rf_wdata=32'hDEAD_BEEF to rd=5.
- Taken branch:
  - Stimulus: `beq`, alu_zero=1, alu_pcout=32'h40.
  - Required: pc_o=32'h40 and rf_we never asserted.
- JALR:
  - Stimulus: `jalr x1,0(x2)`, alu_result=PC+4, alu_pcout=32'h101.
  - Required: rf_wdata=PC+4 to rd=1; pc_o=32'h100.
- Illegal opcode:
  - Stimulus: instruction 32'hFFFF_FFFF with ILLEGAL_TRAP_EN defined; repeat without it.
  - Required with the macro: illegal_o=1, imem_req stays 0, pc_o frozen.
  - Required without the macro: pc_o advances by 4.
